// File: rtl/rst_seq.sv
// Reset sequencer: turns the chip reset and the DCM lock indication into
// staged, synchronously released active-low resets (bus domain first, CPU
// after a fixed gap). It also services software reset requests and records
// why the last reset sequence started.
module rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       soft_rst_req,
  output logic       bus_reset,
  output logic       cpu_reset,
  output logic       rst_busy,
  output logic [1:0] rst_cause
);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    HOLD   = 2'd1,
    BUS_UP = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   bus_n, cpu_n, busy_n;
  logic [1:0]             cause_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  // Bring the asynchronous lock indication into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State, counter and registered reset outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ASSERT;
      cnt       <= '0;
      bus_reset <= 1'b0;
      cpu_reset <= 1'b0;
      rst_busy  <= 1'b1;
      rst_cause <= CAUSE_POR;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bus_reset <= bus_n;
      cpu_reset <= cpu_n;
      rst_busy  <= busy_n;
      rst_cause <= cause_n;
    end
  end

  // Sequencing: lock loss outranks everything, soft reset is honoured only
  // in RUN and restarts at HOLD because the clock is already known good.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bus_n   = bus_reset;
    cpu_n   = cpu_reset;
    busy_n  = rst_busy;
    cause_n = rst_cause;
    if (state != ASSERT && !locked_s) begin
      state_n = ASSERT;
      cnt_n   = '0;
      bus_n   = 1'b0;
      cpu_n   = 1'b0;
      busy_n  = 1'b1;
      cause_n = CAUSE_LOCK;
    end else begin
      unique case (state)
        ASSERT: begin
          bus_n  = 1'b0;
          cpu_n  = 1'b0;
          busy_n = 1'b1;
          cnt_n  = '0;
          if (locked_s) state_n = HOLD;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_n = BUS_UP;
            bus_n   = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        BUS_UP: begin
          if (cnt == GAP_LAST) begin
            state_n = RUN;
            cpu_n   = 1'b1;
            busy_n  = 1'b0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (soft_rst_req) begin
            state_n = HOLD;
            cnt_n   = '0;
            bus_n   = 1'b0;
            cpu_n   = 1'b0;
            busy_n  = 1'b1;
            cause_n = CAUSE_SOFT;
          end
        end
        default: state_n = ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: edge-indexed expectation tables plus
// hand-written sequences for soft reset, lock loss and async abort.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic       soft_rst_req;
  logic       bus_reset;
  logic       cpu_reset;
  logic       rst_busy;
  logic [1:0] rst_cause;

  int n_chk  = 0;
  int n_fail = 0;
  int cur    = 0;

  typedef struct {
    int         at;
    logic [4:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  // {bus, cpu, busy, cause}
  localparam logic [4:0] RST_POR  = 5'b00100;
  localparam logic [4:0] BUS_POR  = 5'b10100;
  localparam logic [4:0] RUN_POR  = 5'b11000;
  localparam logic [4:0] RST_LOCK = 5'b00101;
  localparam logic [4:0] BUS_LOCK = 5'b10101;
  localparam logic [4:0] RUN_LOCK = 5'b11001;
  localparam logic [4:0] RST_SOFT = 5'b00110;
  localparam logic [4:0] BUS_SOFT = 5'b10110;
  localparam logic [4:0] RUN_SOFT = 5'b11010;

  rst_seq dut (
    .clk          (clk),
    .reset        (reset),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .bus_reset    (bus_reset),
    .cpu_reset    (cpu_reset),
    .rst_busy     (rst_busy),
    .rst_cause    (rst_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {bus_reset, cpu_reset, rst_busy, rst_cause};
  endfunction

  task automatic chk(input string nm, input logic [4:0] e);
    n_chk++;
    if (outs() !== e) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %b expected %b (bus,cpu,busy,cause)",
               nm, cur, outs(), e);
    end
  endtask

  // Advance one edge, sample 1ns later; also check CPU never leaves reset
  // before the bus domain.
  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
    if (reset) begin
      n_chk++;
      if (cpu_reset && !bus_reset) begin
        n_fail++;
        $display("FAIL order @edge %0d: cpu_reset=%b bus_reset=%b", cur, cpu_reset, bus_reset);
      end
    end
  endtask

  task automatic tick_to(input int e);
    while (cur < e) tick();
  endtask

  task automatic add(input int at, input logic [4:0] e, input string nm);
    vec_t v;
    v.at = at; v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      tick_to(tbl[i].at);
      chk(tbl[i].nm, tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    reset = 1'b0; locked = 1'b1; soft_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", RST_POR);

    // Power-up with lock already present.
    reset = 1'b1; cur = 0;
    chk("pu_rel", RST_POR);
    add(2,  RST_POR, "pu_e2");
    add(18, RST_POR, "pu_e18");
    add(19, BUS_POR, "pu_bus_e19");
    add(26, BUS_POR, "pu_e26");
    add(27, RUN_POR, "pu_cpu_e27");
    add(35, RUN_POR, "pu_run");
    run_tbl();

    // Soft request in the same cycle locked_s is low: lock loss wins.
    cur = 0; locked = 1'b0;
    tick(); tick();
    chk("both_pre", RUN_POR);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0; locked = 1'b1;
    chk("both_lock_wins", RST_LOCK);
    add(21, RST_LOCK, "both_e21");
    add(22, BUS_LOCK, "both_bus_e22");
    add(29, BUS_LOCK, "both_e29");
    add(30, RUN_LOCK, "both_cpu_e30");
    run_tbl();

    // Soft reset from RUN (T = edge 1); a second request in HOLD is ignored.
    cur = 0; soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("sw_start", RST_SOFT);
    tick_to(5);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("sw_hold_ignored", RST_SOFT);
    add(16, RST_SOFT, "sw_e16");
    add(17, BUS_SOFT, "sw_bus_T16");
    add(24, BUS_SOFT, "sw_e24");
    add(25, RUN_SOFT, "sw_cpu_T24");
    run_tbl();

    // One-cycle lock drop while in RUN.
    cur = 0; locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    chk("ll_e2_still_run", RUN_SOFT);
    tick();
    chk("ll_e3_assert", RST_LOCK);
    add(19, RST_LOCK, "ll_e19");
    add(20, BUS_LOCK, "ll_bus_e20");
    add(27, BUS_LOCK, "ll_e27");
    add(28, RUN_LOCK, "ll_cpu_e28");
    run_tbl();

    // Asynchronous reset in the middle of BUS_UP.
    cur = 0; soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    tick_to(20);
    chk("abort_pre_busup", BUS_SOFT);
    #2 reset = 1'b0;
    #1 chk("abort_async", RST_POR);
    locked = 1'b0;
    tick();
    chk("abort_held", RST_POR);

    // Release without lock for 50 cycles, then lock.
    reset = 1'b1; cur = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("nolock_wait", RST_POR);
    end
    locked = 1'b1; cur = 0;
    add(18, RST_POR, "lk_e18");
    add(19, BUS_POR, "lk_bus_e19");
    add(26, BUS_POR, "lk_e26");
    add(27, RUN_POR, "lk_cpu_e27");
    run_tbl();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
